// File: rtl/ev_motor_pwm_driver.sv
// EV motor gate driver: command target, slew-limited duty ramp, fault/brake
// handling and a period-aligned 8-bit PWM generator.
module ev_motor_pwm_driver #(
    parameter int RAMP_STEP = 4,
    parameter int RAMP_DIV  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] speed_cmd,
    input  logic       cmd_valid,
    input  logic       power_on,
    input  logic       brake_active,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic       pwm_out,
    output logic [7:0] duty_now,
    output logic [1:0] state,
    output logic       ramp_done,
    output logic       fault_latched
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RAMP  = 2'b01,
        RUN   = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [7:0] STEP   = 8'(RAMP_STEP);
    localparam logic [7:0] DIV_M1 = 8'(RAMP_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] duty_q, duty_d;
    logic [7:0] target_q, target_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic       pwm_q, pwm_d;

    logic       tick;
    logic       kill;
    logic [7:0] up_diff;
    logic [7:0] dn_diff;
    logic [7:0] step_duty;

    assign tick    = (presc_q == DIV_M1);
    assign up_diff = target_q - duty_q;
    assign dn_diff = duty_q - target_q;

    // Saturating move toward target: never overshoots, never wraps.
    always_comb begin
        step_duty = duty_q;
        if (target_q > duty_q) begin
            step_duty = duty_q + ((up_diff < STEP) ? up_diff : STEP);
        end else if (target_q < duty_q) begin
            step_duty = duty_q - ((dn_diff < STEP) ? dn_diff : STEP);
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        presc_d  = '0;
        if (fault_in) begin
            state_d  = FAULT;
            duty_d   = '0;
            target_d = '0;
        end else if (state_q == FAULT) begin
            duty_d   = '0;
            target_d = '0;
            if (fault_clr) begin
                state_d = IDLE;
            end
        end else if (brake_active) begin
            state_d  = IDLE;
            duty_d   = '0;
            target_d = '0;
        end else begin
            if (!power_on) begin
                target_d = '0;
            end else if (cmd_valid) begin
                target_d = speed_cmd;
            end
            unique case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (target_q != 8'd0) begin
                        state_d = RAMP;
                    end
                end
                RAMP: begin
                    presc_d = tick ? 8'd0 : presc_q + 8'd1;
                    if (tick) begin
                        duty_d = step_duty;
                    end
                    if (duty_q == target_q && target_q != 8'd0) begin
                        state_d = RUN;
                    end else if (duty_q == 8'd0 && target_q == 8'd0) begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (target_q != duty_q) begin
                        state_d = RAMP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Shadow only updates at period end so each PWM period is glitch-free.
    always_comb begin
        kill      = fault_in | brake_active | (state_q == FAULT);
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        shadow_d  = shadow_q;
        pwm_d     = (pwm_cnt_q < shadow_q);
        if (kill) begin
            shadow_d = '0;
            pwm_d    = 1'b0;
        end else if (pwm_cnt_q == 8'hFF) begin
            shadow_d = duty_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            target_q  <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            shadow_q  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            shadow_q  <= shadow_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign duty_now      = duty_q;
    assign state         = state_q;
    assign ramp_done     = (state_q == RUN);
    assign fault_latched = (state_q == FAULT);

endmodule

// File: tb/tb_ev_motor_pwm_driver.sv
// Self-checking bench for ev_motor_pwm_driver: ramp scoreboard, PWM duty,
// brake, fault latch, power loss and asynchronous reset.
module tb_ev_motor_pwm_driver;

    localparam int STEP = 4;
    localparam int DIV  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] speed_cmd;
    logic       cmd_valid;
    logic       power_on;
    logic       brake_active;
    logic       fault_in;
    logic       fault_clr;
    logic       pwm_out;
    logic [7:0] duty_now;
    logic [1:0] state;
    logic       ramp_done;
    logic       fault_latched;

    int n_vec = 0;
    int n_bad = 0;
    int exp_duty[$];
    int exp_gap[$];
    int hi;

    ev_motor_pwm_driver #(
        .RAMP_STEP(STEP),
        .RAMP_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .speed_cmd    (speed_cmd),
        .cmd_valid    (cmd_valid),
        .power_on     (power_on),
        .brake_active (brake_active),
        .fault_in     (fault_in),
        .fault_clr    (fault_clr),
        .pwm_out      (pwm_out),
        .duty_now     (duty_now),
        .state        (state),
        .ramp_done    (ramp_done),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected duty steps and their spacing in cycles after the load edge.
    task automatic push_ramp(input int from, input int to);
        int d;
        int delta;
        bit first;
        d     = from;
        first = 1'b1;
        while (d != to) begin
            if (to > d) delta = (to - d < STEP) ? to - d : STEP;
            else        delta = -((d - to < STEP) ? d - to : STEP);
            d += delta;
            exp_duty.push_back(d);
            exp_gap.push_back(first ? DIV + 1 : DIV);
            first = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        logic [7:0] prev;
        int gap;
        int ed;
        int eg;
        prev = duty_now;
        while (exp_duty.size() > 0) begin
            ed  = exp_duty.pop_front();
            eg  = exp_gap.pop_front();
            gap = 0;
            do begin
                tick();
                gap++;
            end while (duty_now == prev && gap < eg + 4);
            if (duty_now == prev) begin
                chk({tag, "_timeout"}, gap, eg);
                exp_duty.delete();
                exp_gap.delete();
            end else begin
                chk({tag, "_duty"}, duty_now, ed);
                chk({tag, "_gap"}, gap, eg);
                prev = duty_now;
            end
        end
    endtask

    task automatic send_cmd(input logic [7:0] v);
        speed_cmd = v;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count_hi();
        hi = 0;
        repeat (256) begin
            tick();
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        rst          = 1'b1;
        speed_cmd    = 8'd0;
        cmd_valid    = 1'b0;
        power_on     = 1'b1;
        brake_active = 1'b0;
        fault_in     = 1'b0;
        fault_clr    = 1'b0;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_duty", duty_now, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_done", ramp_done, 0);
        chk("rst_flt", fault_latched, 0);
        rst = 1'b0;
        repeat (20) tick();
        chk("idle_stay", state, 0);

        push_ramp(0, 8'h40);
        send_cmd(8'h40);
        drain("up40");
        tick();
        chk("run40_state", state, 2);
        chk("run40_done", ramp_done, 1);
        repeat (260) tick();
        count_hi();
        chk("pwm40_hi", hi, 64);

        push_ramp(8'h40, 8'h80);
        send_cmd(8'h80);
        drain("up80");
        tick();
        chk("run80_state", state, 2);

        brake_active = 1'b1;
        tick();
        chk("brk_duty", duty_now, 0);
        chk("brk_state", state, 0);
        chk("brk_pwm", pwm_out, 0);
        speed_cmd = 8'h50;
        cmd_valid = 1'b1;
        repeat (5) tick();
        brake_active = 1'b0;
        cmd_valid    = 1'b0;
        repeat (5) tick();
        chk("brk_tgt_state", state, 0);
        chk("brk_tgt_duty", duty_now, 0);
        count_hi();
        chk("pwm0_hi", hi, 0);

        push_ramp(0, 8'h0A);
        send_cmd(8'h0A);
        drain("sat");
        tick();
        chk("sat_state", state, 2);
        repeat (40) tick();
        chk("sat_hold", duty_now, 8'h0A);

        send_cmd(8'h40);
        repeat (30) tick();
        chk("flt_pre", state, 1);
        fault_in = 1'b1;
        tick();
        chk("flt_state", state, 3);
        chk("flt_latch", fault_latched, 1);
        chk("flt_pwm", pwm_out, 0);
        chk("flt_duty", duty_now, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("flt_clr_blk", state, 3);
        fault_in = 1'b0;
        repeat (3) tick();
        chk("flt_hold", state, 3);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("flt_exit", state, 0);
        chk("flt_exit_latch", fault_latched, 0);
        repeat (5) tick();
        chk("flt_idle", state, 0);

        push_ramp(0, 8'h20);
        send_cmd(8'h20);
        drain("up20");
        tick();
        chk("run20_state", state, 2);
        push_ramp(8'h20, 0);
        power_on = 1'b0;
        tick();
        drain("down");
        tick();
        chk("down_state", state, 0);

        power_on = 1'b1;
        send_cmd(8'h40);
        repeat (40) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_duty", duty_now, 0);
        chk("arst_pwm", pwm_out, 0);
        chk("arst_done", ramp_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        chk("arst_idle", state, 0);

        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        chk("arst_f_pre", state, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_f_state", state, 0);
        chk("arst_f_latch", fault_latched, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ev_motor_pwm_driver.md
EV_MOTOR_PWM_DRIVER -- requirements
Module: ev_motor_pwm_driver

Interface
REQ-001 Parameter RAMP_STEP, default 4: maximum duty change per ramp tick, range 1..255.
REQ-002 Parameter RAMP_DIV, default 16: clk cycles per ramp tick, range 1..256.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 speed_cmd  input  8: requested duty; the motor-control stage supplies (accel-brake)*16.
REQ-006 cmd_valid  input  1: when high, speed_cmd is sampled into the target register this cycle.
REQ-007 power_on  input  1: system enable (PLC or HMI power).
REQ-008 brake_active  input  1: brake request; forces an immediate stop.
REQ-009 fault_in  input  1: external fault (overcurrent/overtemp), level-sensitive.
REQ-010 fault_clr  input  1: single-cycle pulse that clears a latched fault.
REQ-011 pwm_out  output  1: registered motor gate drive.
REQ-012 duty_now  output  8: current ramped duty.
REQ-013 state  output  2: IDLE=00, RAMP=01, RUN=10, FAULT=11.
REQ-014 ramp_done  output  1: high while in RUN.
REQ-015 fault_latched  output  1: high while in FAULT.

Function
REQ-016 Target register: on cmd_valid, load speed_cmd if power_on=1, else load 0; when power_on=0, force target to 0 every cycle regardless of cmd_valid.
REQ-017 IDLE: duty=0; go to RAMP when target!=0 and brake_active=0.
REQ-018 RAMP prescaler: clear on entry to RAMP; count 0..RAMP_DIV-1; raise a tick on the cycle the count equals RAMP_DIV-1, then wrap to 0.
REQ-019 On each tick, move duty toward target by min(RAMP_STEP, |target-duty|): saturating, no overshoot, no 8-bit wrap.
REQ-020 RAMP to RUN on the cycle after duty becomes equal to target when target!=0; RAMP to IDLE when duty=0 and target=0.
REQ-021 RUN: duty holds; go to RAMP on the cycle after target differs from duty.
REQ-022 brake_active=1 in IDLE, RAMP or RUN: next cycle duty=0, target=0, state=IDLE; target loads stay blocked while brake_active=1.
REQ-023 fault_in=1 in any state: next cycle state=FAULT, duty=0, target=0.
REQ-024 FAULT: exit to IDLE only on fault_clr=1 with fault_in=0 in the same cycle; all other inputs are ignored.
REQ-025 Priority, highest first: fault_in, brake_active, power_on, cmd_valid.
REQ-026 PWM counter: 8-bit, free-running, increments every cycle, wraps 255 to 0, never stops outside reset.
REQ-027 duty_shadow: load from duty only on the cycle the PWM counter equals 255, so duty changes take effect at period start.
REQ-028 pwm_out: registered as (pwm_cnt < duty_shadow), giving one cycle of latency.
REQ-029 Duty 0 gives pwm_out constantly low; duty 255 gives 255 high cycles per 256-cycle period.
REQ-030 pwm_out is forced low on the cycle after entry to FAULT or brake, overriding duty_shadow; duty_shadow is cleared at the same time.

Reset
REQ-031 While rst=1: state=IDLE, duty_now=0, target=0, duty_shadow=0, pwm_cnt=0, prescaler=0, pwm_out=0, ramp_done=0, fault_latched=0.
REQ-032 Asserting rst mid-ramp or while in FAULT returns the block to the REQ-031 values immediately, with no clk edge required.
REQ-033 After rst deasserts, the block stays in IDLE until a nonzero target is loaded.

Verification
REQ-034 Ramp up: power_on=1, cmd_valid pulse with speed_cmd=0x40 -> RAMP; duty_now steps by 4 every 16 cycles; reaches 0x40 after 16 ticks (256 cycles); then state=RUN and ramp_done=1.
REQ-035 Saturation: speed_cmd=0x0A from duty 0 -> duty sequence 4, 8, 0x0A; then RUN; duty never exceeds 0x0A.
REQ-036 PWM shape: run at duty 0x40 -> in each 256-cycle period pwm_out is high exactly 64 cycles; a duty change mid-period appears only from the next period.
REQ-037 Brake in RUN at duty 0x80 -> next cycle duty_now=0, state=IDLE, pwm_out=0; cmd_valid held during brake_active=1 leaves target=0.
REQ-038 Fault: fault_in=1 during RAMP -> state=FAULT, fault_latched=1, pwm_out=0; fault_clr with fault_in=1 is ignored; fault_clr with fault_in=0 returns state to IDLE.
REQ-039 Power loss: power_on falls in RUN at duty 0x20 -> ramps down 4 per tick to 0, then IDLE; asserting rst mid-ramp gives all outputs 0 with no clk edge.
